// File: rtl/tv80_pkg.sv
// Shared TV80 bus-controller types: cycle classes, T-state bit positions
// and wait-generator state encoding.
package tv80_pkg;

    typedef enum logic [1:0] {
        CYC_M1,
        CYC_MEM,
        CYC_IO
    } cyc_class_e;

    localparam int unsigned T1 = 1;
    localparam int unsigned T2 = 2;
    localparam int unsigned T3 = 3;
    localparam int unsigned T4 = 4;

    typedef enum logic {
        ST_IDLE,
        ST_WAIT
    } wait_state_e;

    function automatic cyc_class_e decode_class(input logic m1, input logic iorq);
        if (m1)
            return CYC_M1;
        else if (iorq)
            return CYC_IO;
        else
            return CYC_MEM;
    endfunction

endpackage

// File: rtl/tv80_wait_gen.sv
// Internal wait-state generator: stretches T2 by a per-cycle-class count
// and merges the external wait request into the core's wait input.
module tv80_wait_gen
    import tv80_pkg::*;
(
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       t2_i,
    input  logic [3:0] wait_cnt_i,
    input  logic       ext_wait_n_i,
    output logic       core_wait_n_o,
    output logic       busy_o
);

    wait_state_e state_q;
    logic [3:0]  cnt_q;
    logic        busy_q;

    // WAIT is held at cnt 0 until ext_wait_n rises, so a T2 stretched by the
    // external wait cannot re-arm the internal count on the same cycle.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            busy_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (t2_i && (wait_cnt_i != 4'd0)) begin
                        state_q <= ST_WAIT;
                        cnt_q   <= wait_cnt_i - 4'd1;
                        busy_q  <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else if (ext_wait_n_i) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign core_wait_n_o = ext_wait_n_i
                         && !((state_q == ST_WAIT) && (cnt_q != 4'd0))
                         && !((state_q == ST_IDLE) && t2_i && (wait_cnt_i != 4'd0));
    assign busy_o = busy_q;

endmodule

// File: rtl/tv80_bus_ctrl.sv
// TV80 bus-cycle controller: falling-edge registered Z80 strobes, internal
// wait states per cycle class, M1 refresh and rising-edge read-data latch.
module tv80_bus_ctrl
    import tv80_pkg::*;
#(
    parameter int unsigned DW       = 8,
    parameter int unsigned M1_WAIT  = 0,
    parameter int unsigned MEM_WAIT = 0,
    parameter int unsigned IO_WAIT  = 1,
    parameter int unsigned T2WRITE  = 0,
    parameter int unsigned RFSH_EN  = 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic [6:0]    mcycle,
    input  logic [6:0]    tstate,
    input  logic          intcycle_n,
    input  logic          no_read,
    input  logic          write,
    input  logic          iorq,
    input  logic          rfsh_n,
    input  logic          ext_wait_n,
    input  logic [DW-1:0] di,
    output logic          core_wait_n,
    output logic          mreq_n,
    output logic          iorq_n,
    output logic          rd_n,
    output logic          wr_n,
    output logic [DW-1:0] di_reg,
    output logic          busy
);

    localparam logic [3:0] M1_W  = 4'(M1_WAIT);
    localparam logic [3:0] MEM_W = 4'(MEM_WAIT);
    localparam logic [3:0] IO_W  = 4'(IO_WAIT);

    cyc_class_e    cls;
    logic [3:0]    wait_sel;
    logic          wr_act;
    logic          mreq_n_d, iorq_n_d, rd_n_d, wr_n_d;
    logic          mreq_n_q, iorq_n_q, rd_n_q, wr_n_q;
    logic [DW-1:0] di_reg_q;
    logic          unused_bits;

    assign unused_bits = ^{mcycle[6:1], tstate[6:5], tstate[0]};

    always_comb begin
        cls = decode_class(mcycle[0], iorq);
        case (cls)
            CYC_M1:  wait_sel = M1_W;
            CYC_IO:  wait_sel = IO_W;
            default: wait_sel = MEM_W;
        endcase
    end

    tv80_wait_gen u_wait_gen (
        .clk_i         (clk),
        .rst_i         (reset),
        .t2_i          (tstate[T2]),
        .wait_cnt_i    (wait_sel),
        .ext_wait_n_i  (ext_wait_n),
        .core_wait_n_o (core_wait_n),
        .busy_o        (busy)
    );

    always_comb begin
        mreq_n_d = 1'b1;
        iorq_n_d = 1'b1;
        rd_n_d   = 1'b1;
        wr_n_d   = 1'b1;
        wr_act   = 1'b0;
        if (cls == CYC_M1) begin
            if (tstate[T1] || tstate[T2]) begin
                rd_n_d   = !intcycle_n;
                mreq_n_d = !intcycle_n;
                iorq_n_d = intcycle_n;
            end else if ((tstate[T3] || tstate[T4]) && (RFSH_EN != 0) && !rfsh_n) begin
                mreq_n_d = 1'b0;
            end
        end else begin
            if ((tstate[T1] || tstate[T2]) && !no_read && !write) begin
                rd_n_d   = 1'b0;
                iorq_n_d = !iorq;
                mreq_n_d = iorq;
            end
            if (write) begin
                if (T2WRITE != 0)
                    wr_act = tstate[T1] || (tstate[T2] && !core_wait_n);
                else
                    wr_act = tstate[T2] && core_wait_n;
            end
            if (wr_act) begin
                wr_n_d   = 1'b0;
                iorq_n_d = !iorq;
                mreq_n_d = iorq;
            end
        end
    end

    always_ff @(negedge clk or posedge reset) begin
        if (reset) begin
            mreq_n_q <= 1'b1;
            iorq_n_q <= 1'b1;
            rd_n_q   <= 1'b1;
            wr_n_q   <= 1'b1;
        end else begin
            mreq_n_q <= mreq_n_d;
            iorq_n_q <= iorq_n_d;
            rd_n_q   <= rd_n_d;
            wr_n_q   <= wr_n_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            di_reg_q <= '0;
        else if (tstate[T2] && core_wait_n)
            di_reg_q <= di;
    end

    assign mreq_n = mreq_n_q;
    assign iorq_n = iorq_n_q;
    assign rd_n   = rd_n_q;
    assign wr_n   = wr_n_q;
    assign di_reg = di_reg_q;

endmodule
